// File: rtl/rob_commit_module_pkg.sv
// Shared types and sizes for the reorder buffer commit block.
// Optional feature macro used by this block: ROB_WB_BYPASS_EN.
package rob_commit_module_pkg;

    localparam int ROB_SIZE     = 8;
    localparam int ROB_IDX_SIZE = $clog2(ROB_SIZE);
    localparam int GPR_IDX_SIZE = 5;
    localparam int VALUE_SIZE   = 64;

    typedef logic [3:0] nzcv_t;

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic                    writes_reg;
        logic                    set_nzcv;
        logic [GPR_IDX_SIZE-1:0] dst;
        logic [VALUE_SIZE-1:0]   value;
        nzcv_t                   nzcv;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_module_if.sv
// Dispatch, writeback, flush and commit signals of the reorder buffer.
// valid/ready: an allocation is taken on a clock edge only when in_alloc_valid and out_alloc_ready are both high.
interface rob_commit_module_if;
    import rob_commit_module_pkg::*;

    logic                    in_alloc_valid;
    logic [GPR_IDX_SIZE-1:0] in_alloc_dst;
    logic                    in_alloc_writes_reg;
    logic                    in_alloc_set_nzcv;
    logic                    out_alloc_ready;
    logic [ROB_IDX_SIZE-1:0] out_next_rob_index;

    logic                    in_wb_valid;
    logic [ROB_IDX_SIZE-1:0] in_wb_rob_index;
    logic [VALUE_SIZE-1:0]   in_wb_value;
    nzcv_t                   in_wb_nzcv;

    logic                    in_flush;

    logic                    out_commit_done;
    logic [ROB_IDX_SIZE-1:0] out_commit_rob_index;
    logic [GPR_IDX_SIZE-1:0] out_commit_reg_index;
    logic                    out_commit_writes_reg;
    logic [VALUE_SIZE-1:0]   out_commit_value;
    logic                    out_commit_set_nzcv;
    nzcv_t                   out_commit_nzcv;
    logic [ROB_IDX_SIZE:0]   out_count;
    logic                    out_alloc_error;

    modport slave (
        input  in_alloc_valid, in_alloc_dst, in_alloc_writes_reg, in_alloc_set_nzcv,
        input  in_wb_valid, in_wb_rob_index, in_wb_value, in_wb_nzcv, in_flush,
        output out_alloc_ready, out_next_rob_index,
        output out_commit_done, out_commit_rob_index, out_commit_reg_index,
        output out_commit_writes_reg, out_commit_value, out_commit_set_nzcv,
        output out_commit_nzcv, out_count, out_alloc_error
    );

    modport master (
        output in_alloc_valid, in_alloc_dst, in_alloc_writes_reg, in_alloc_set_nzcv,
        output in_wb_valid, in_wb_rob_index, in_wb_value, in_wb_nzcv, in_flush,
        input  out_alloc_ready, out_next_rob_index,
        input  out_commit_done, out_commit_rob_index, out_commit_reg_index,
        input  out_commit_writes_reg, out_commit_value, out_commit_set_nzcv,
        input  out_commit_nzcv, out_count, out_alloc_error
    );

endinterface

// File: rtl/rob_commit_module_circ_ptr.sv
// Circular pointer with an extra wrap bit; load takes priority over increment.
module rob_circ_ptr #(
    parameter int IDX_W = 3
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_inc,
    input  logic             in_load,
    input  logic [IDX_W:0]   in_load_val,
    output logic [IDX_W:0]   out_ptr
);

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_ptr <= '0;
        end else if (in_load) begin
            out_ptr <= in_load_val;
        end else if (in_inc) begin
            out_ptr <= out_ptr + (IDX_W + 1)'(1);
        end
    end

endmodule

// File: rtl/rob_commit_module.sv
// In-order reorder buffer: allocates at tail, completes out of order, retires from head.
// Optional: ROB_WB_BYPASS_EN lets a writeback to the head entry commit on the same edge.
module rob_commit_module
    import rob_commit_module_pkg::*;
(
    input  logic in_clk,
    input  logic in_rst,
    rob_commit_module_if.slave bus
);

    logic [ROB_IDX_SIZE:0]   head;
    logic [ROB_IDX_SIZE:0]   tail;
    logic [ROB_IDX_SIZE-1:0] head_idx;
    logic [ROB_IDX_SIZE-1:0] tail_idx;
    logic                    full;
    logic                    empty;
    logic                    alloc_fire;
    logic                    wb_accept;
    logic                    bypass;
    logic                    commit_fire;
    logic [VALUE_SIZE-1:0]   commit_value;
    nzcv_t                   commit_nzcv;
    rob_entry_t              entries [ROB_SIZE];

    assign head_idx = head[ROB_IDX_SIZE-1:0];
    assign tail_idx = tail[ROB_IDX_SIZE-1:0];
    assign full     = (head_idx == tail_idx) && (head[ROB_IDX_SIZE] != tail[ROB_IDX_SIZE]);
    assign empty    = (head == tail);

    assign bus.out_alloc_ready    = !full;
    assign bus.out_next_rob_index = tail_idx;
    assign bus.out_count          = tail - head;

    assign alloc_fire = bus.in_alloc_valid && !full && !bus.in_flush;
    // A second writeback to an already-completed entry must not overwrite its result.
    assign wb_accept  = bus.in_wb_valid && entries[bus.in_wb_rob_index].valid
                        && !entries[bus.in_wb_rob_index].ready && !bus.in_flush;

`ifdef ROB_WB_BYPASS_EN
    assign bypass = wb_accept && (bus.in_wb_rob_index == head_idx);
`else
    assign bypass = 1'b0;
`endif

    assign commit_fire  = !bus.in_flush && !empty && entries[head_idx].valid
                          && (entries[head_idx].ready || bypass);
    assign commit_value = bypass ? bus.in_wb_value : entries[head_idx].value;
    assign commit_nzcv  = bypass ? bus.in_wb_nzcv  : entries[head_idx].nzcv;

    rob_circ_ptr #(.IDX_W(ROB_IDX_SIZE)) u_head_ptr (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_inc      (commit_fire),
        .in_load     (1'b0),
        .in_load_val ('0),
        .out_ptr     (head)
    );

    // Flush snaps tail back onto head, emptying the buffer in one edge.
    rob_circ_ptr #(.IDX_W(ROB_IDX_SIZE)) u_tail_ptr (
        .in_clk      (in_clk),
        .in_rst      (in_rst),
        .in_inc      (alloc_fire),
        .in_load     (bus.in_flush),
        .in_load_val (head),
        .out_ptr     (tail)
    );

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i] <= '0;
            end
        end else if (bus.in_flush) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entries[i].valid <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            if (wb_accept) begin
                entries[bus.in_wb_rob_index].ready <= 1'b1;
                entries[bus.in_wb_rob_index].value <= bus.in_wb_value;
                entries[bus.in_wb_rob_index].nzcv  <= bus.in_wb_nzcv;
            end
            // Placed after the writeback so a bypassed head never stays marked ready.
            if (commit_fire) begin
                entries[head_idx].valid <= 1'b0;
                entries[head_idx].ready <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail_idx] <= '{
                    valid:      1'b1,
                    ready:      1'b0,
                    writes_reg: bus.in_alloc_writes_reg,
                    set_nzcv:   bus.in_alloc_set_nzcv,
                    dst:        bus.in_alloc_dst,
                    value:      '0,
                    nzcv:       '0
                };
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            bus.out_commit_done       <= 1'b0;
            bus.out_commit_rob_index  <= '0;
            bus.out_commit_reg_index  <= '0;
            bus.out_commit_writes_reg <= 1'b0;
            bus.out_commit_value      <= '0;
            bus.out_commit_set_nzcv   <= 1'b0;
            bus.out_commit_nzcv       <= '0;
            bus.out_alloc_error       <= 1'b0;
        end else begin
            bus.out_commit_done <= commit_fire;
            if (commit_fire) begin
                bus.out_commit_rob_index  <= head_idx;
                bus.out_commit_reg_index  <= entries[head_idx].dst;
                bus.out_commit_writes_reg <= entries[head_idx].writes_reg;
                bus.out_commit_value      <= commit_value;
                bus.out_commit_set_nzcv   <= entries[head_idx].set_nzcv;
                bus.out_commit_nzcv       <= commit_nzcv;
            end
            if (bus.in_alloc_valid && full) begin
                bus.out_alloc_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_module.sv
// Randomised scoreboard bench for rob_commit_module against a program-order queue model.
module tb_rob_commit_module;
    import rob_commit_module_pkg::*;

    localparam int CW = ROB_IDX_SIZE + GPR_IDX_SIZE + 1 + VALUE_SIZE + 1 + 4;

    typedef struct {
        int                      idx;
        logic [GPR_IDX_SIZE-1:0] dst;
        logic                    wr;
        logic                    sn;
        logic                    done;
        logic [VALUE_SIZE-1:0]   val;
        logic [3:0]              nz;
    } m_ent_t;

    logic in_clk = 1'b0;
    logic in_rst = 1'b1;
    int   cyc = 0;

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    rob_commit_module_if bus();

    rob_commit_module dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [CW-1:0] exp_q[$];
    int            exp_t[$];
    m_ent_t        mq[$];
    int            m_hd  = 0;
    logic          m_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: entries live in a program-order queue; the head retires once its result is known.
    task automatic model_step(input logic a_v, input logic [GPR_IDX_SIZE-1:0] a_dst,
                              input logic a_wr, input logic a_sn, input logic w_v,
                              input logic [ROB_IDX_SIZE-1:0] w_idx, input logic [VALUE_SIZE-1:0] w_val,
                              input logic [3:0] w_nz, input logic fl);
        int     pre_size = mq.size();
        int     tail_idx = (m_hd + pre_size) % ROB_SIZE;
        int     wpos = -1;
        bit     do_commit = 0;
        m_ent_t e;
        if (a_v && pre_size == ROB_SIZE) m_err = 1'b1;
        if (fl) begin
            mq.delete();
            return;
        end
        if (w_v)
            for (int i = 0; i < pre_size; i++)
                if (mq[i].idx == int'(w_idx) && !mq[i].done) wpos = i;
        if (pre_size > 0) begin
            if (mq[0].done) do_commit = 1;
`ifdef ROB_WB_BYPASS_EN
            if (wpos == 0) do_commit = 1;
`endif
        end
        if (wpos >= 0) begin
            mq[wpos].done = 1'b1;
            mq[wpos].val  = w_val;
            mq[wpos].nz   = w_nz;
        end
        if (do_commit) begin
            e = mq.pop_front();
            exp_q.push_back({ROB_IDX_SIZE'(e.idx), e.dst, e.wr, e.val, e.sn, e.nz});
            exp_t.push_back(cyc + 1);
            m_hd = (m_hd + 1) % ROB_SIZE;
        end
        if (a_v && pre_size < ROB_SIZE) begin
            e.idx = tail_idx; e.dst = a_dst; e.wr = a_wr; e.sn = a_sn;
            e.done = 1'b0; e.val = '0; e.nz = '0;
            mq.push_back(e);
        end
    endtask

    task automatic step(input logic a_v, input logic [GPR_IDX_SIZE-1:0] a_dst,
                        input logic a_wr, input logic a_sn, input logic w_v,
                        input logic [ROB_IDX_SIZE-1:0] w_idx, input logic [VALUE_SIZE-1:0] w_val,
                        input logic [3:0] w_nz, input logic fl);
        @(negedge in_clk);
        bus.in_alloc_valid      = a_v;
        bus.in_alloc_dst        = a_dst;
        bus.in_alloc_writes_reg = a_wr;
        bus.in_alloc_set_nzcv   = a_sn;
        bus.in_wb_valid         = w_v;
        bus.in_wb_rob_index     = w_idx;
        bus.in_wb_value         = w_val;
        bus.in_wb_nzcv          = w_nz;
        bus.in_flush            = fl;
        model_step(a_v, a_dst, a_wr, a_sn, w_v, w_idx, w_val, w_nz, fl);
        @(posedge in_clk);
        #1;
        chk("count", 128'(bus.out_count), 128'(mq.size()));
        chk("next_rob_index", 128'(bus.out_next_rob_index), 128'((m_hd + mq.size()) % ROB_SIZE));
        chk("alloc_ready", 128'(bus.out_alloc_ready), 128'(mq.size() < ROB_SIZE));
        chk("alloc_error", 128'(bus.out_alloc_error), 128'(m_err));
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic alloc(input logic [GPR_IDX_SIZE-1:0] d, input logic wr, input logic sn);
        step(1'b1, d, wr, sn, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wb(input logic [ROB_IDX_SIZE-1:0] idx, input logic [VALUE_SIZE-1:0] v,
                      input logic [3:0] nz);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, idx, v, nz, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge in_clk);
        #1;
        in_rst = 1'b1;
        bus.in_alloc_valid = 1'b0; bus.in_alloc_dst = '0; bus.in_alloc_writes_reg = 1'b0;
        bus.in_alloc_set_nzcv = 1'b0; bus.in_wb_valid = 1'b0; bus.in_wb_rob_index = '0;
        bus.in_wb_value = '0; bus.in_wb_nzcv = '0; bus.in_flush = 1'b0;
        mq.delete(); exp_q.delete(); exp_t.delete();
        m_hd = 0; m_err = 1'b0;
        #1;
        chk("async_rst_count", 128'(bus.out_count), 128'(0));
        chk("async_rst_done", 128'(bus.out_commit_done), 128'(0));
        @(posedge in_clk);
        #1;
        chk("rst_next_rob_index", 128'(bus.out_next_rob_index), 128'(0));
        chk("rst_alloc_ready", 128'(bus.out_alloc_ready), 128'(1));
        chk("rst_alloc_error", 128'(bus.out_alloc_error), 128'(0));
        chk("rst_commit_fields", 128'({bus.out_commit_rob_index, bus.out_commit_reg_index,
            bus.out_commit_writes_reg, bus.out_commit_value, bus.out_commit_set_nzcv,
            bus.out_commit_nzcv}), 128'(0));
        @(negedge in_clk);
        #1;
        in_rst = 1'b0;
    endtask

    // Complete every outstanding entry, then let the commits retire.
    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || exp_q.size() != 0) && n < 60) begin
            int tgt = -1;
            for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].done) tgt = mq[i].idx;
            if (tgt >= 0) wb(ROB_IDX_SIZE'(tgt), {$urandom, $urandom}, 4'($urandom_range(0, 15)));
            else idle();
            n++;
        end
        idle();
        chk("drained", 128'(mq.size() + exp_q.size()), 128'(0));
    endtask

    always @(negedge in_clk) begin
        if (!in_rst && bus.out_commit_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("commit_expected", 128'(exp_q.size()), 128'(1));
            end else begin
                chk("commit_cycle", 128'(cyc), 128'(exp_t.pop_front()));
                chk("commit", 128'({bus.out_commit_rob_index, bus.out_commit_reg_index,
                    bus.out_commit_writes_reg, bus.out_commit_value, bus.out_commit_set_nzcv,
                    bus.out_commit_nzcv}), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        do_reset();

        alloc(5'd3, 1'b1, 1'b0);
        alloc(5'd5, 1'b1, 1'b0);
        alloc(5'd7, 1'b1, 1'b0);
        wb(3'd2, 64'd30, 4'd0);
        wb(3'd1, 64'd20, 4'd0);
        wb(3'd0, 64'd10, 4'd0);
        repeat (4) idle();

        do_reset();
        for (int i = 0; i < ROB_SIZE; i++) alloc(5'(i + 1), 1'b1, 1'b0);
        alloc(5'd9, 1'b1, 1'b0);
        wb(3'd0, 64'h1234, 4'd1);
        idle();
        alloc(5'd10, 1'b1, 1'b0);
        drain();

        alloc(5'd0, 1'b0, 1'b1);
        wb(3'((m_hd + mq.size() - 1) % ROB_SIZE), 64'd77, 4'b0110);
        repeat (2) idle();

        repeat (4) alloc(5'($urandom_range(0, 31)), 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 3'(m_hd), 64'd55, 4'd2, 1'b1);
        repeat (2) idle();

        for (int it = 0; it < 400; it++) begin
            if (it == 200) do_reset();
            step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 6),
                 3'($urandom_range(0, ROB_SIZE - 1)), {$urandom, $urandom},
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
